tilt_calc_sequencer: RTL

//  Sequences one fixture-tilt computation: squares and sums target offsets dx/dy, drives the shared

---
 rtl/tilt_calc_sequencer_if.sv | 34 +++
 rtl/tilt_calc_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/tilt_calc_sequencer_if.sv
// Request, result and sqrt/divider core handshake bundle for the tilt sequencer.
// master is the sequencer's view; slave is the view of whatever surrounds it.
interface tilt_calc_sequencer_if;
  logic               start;
  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic        [11:0] height;
  logic               busy;
  logic               sqrt_start;
  logic        [23:0] sqrt_in;
  logic               sqrt_ready;
  logic        [11:0] sqrt_out;
  logic               div_start;
  logic        [11:0] div_dividend;
  logic        [11:0] div_divisor;
  logic               div_ready;
  logic        [11:0] div_quotient;
  logic        [11:0] tilt_ratio;
  logic               d_greater_than_h;
  logic               result_valid;
  logic               timeout_err;

  modport master (
    input  start, dx, dy, height, sqrt_ready, sqrt_out, div_ready, div_quotient,
    output busy, sqrt_start, sqrt_in, div_start, div_dividend, div_divisor,
           tilt_ratio, d_greater_than_h, result_valid, timeout_err
  );

  modport slave (
    output start, dx, dy, height, sqrt_ready, sqrt_out, div_ready, div_quotient,
    input  busy, sqrt_start, sqrt_in, div_start, div_dividend, div_divisor,
           tilt_ratio, d_greater_than_h, result_valid, timeout_err
  );
endinterface

// File: rtl/tilt_calc_sequencer.sv
// Computes one fixture tilt ratio: |d|^2 -> sqrt core -> order against height -> divider.
// Sole master of the shared sqrt and divider cores; returns a UQ0.12 ratio and a d>h flag.
//
// state        | meaning
// IDLE         | waiting for start; operands latched on start
// SQUARE       | sqrt_in <= dx^2 + dy^2
// SQRT_START   | one-cycle sqrt_start pulse, timeout counter loaded
// SQRT_WAIT    | waiting for sqrt_ready (or timeout)
// ORDER        | pick dividend/divisor, decide divide or bypass
// DIV_START    | one-cycle div_start pulse, timeout counter loaded
// DIV_WAIT     | waiting for div_ready (or timeout)
// BYPASS       | ratio already known (0x000 or 0xFFF), no divide needed
// DONE         | result_valid pulse
module tilt_calc_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  tilt_calc_sequencer_if.master  bus
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SQUARE, S_SQRT_START, S_SQRT_WAIT, S_ORDER,
    S_DIV_START, S_DIV_WAIT, S_BYPASS, S_DONE
  } state_t;

  state_t state, next_state;

  logic [11:0]   dx_q, dy_q, height_q, root_q, ratio_q;
  logic          flag_q;
  logic [CW-1:0] cnt_q;
  logic [23:0]   sqrt_in_q;
  logic [11:0]   dividend_q, divisor_q, tilt_q;
  logic          d_gt_h_q, timeout_q;

  logic [11:0] abs_dx, abs_dy;
  logic [23:0] abs_dx_w, abs_dy_w, sum_sq;
  logic        tc_hit, root_gt_h, root_eq_h;

  always_comb begin
    abs_dx    = dx_q[11] ? (~dx_q + 12'd1) : dx_q;
    abs_dy    = dy_q[11] ? (~dy_q + 12'd1) : dy_q;
    abs_dx_w  = {12'd0, abs_dx};
    abs_dy_w  = {12'd0, abs_dy};
    sum_sq    = abs_dx_w * abs_dx_w + abs_dy_w * abs_dy_w;
    tc_hit    = (cnt_q == '0);
    root_gt_h = (root_q > height_q);
    root_eq_h = (root_q == height_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:       if (bus.start) next_state = S_SQUARE;
      S_SQUARE:     next_state = S_SQRT_START;
      S_SQRT_START: next_state = S_SQRT_WAIT;
      S_SQRT_WAIT: begin
        if (bus.sqrt_ready) next_state = S_ORDER;
        else if (tc_hit)    next_state = S_IDLE;
      end
      // root==height also covers the both-zero case, so no divisor can be zero here
      S_ORDER:      next_state = root_eq_h ? S_BYPASS : S_DIV_START;
      S_DIV_START:  next_state = S_DIV_WAIT;
      S_DIV_WAIT: begin
        if (bus.div_ready) next_state = S_DONE;
        else if (tc_hit)   next_state = S_IDLE;
      end
      S_BYPASS:     next_state = S_DONE;
      S_DONE:       next_state = S_IDLE;
      default:      next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = (state != S_IDLE);
    bus.sqrt_start   = (state == S_SQRT_START);
    bus.div_start    = (state == S_DIV_START);
    bus.result_valid = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dx_q       <= '0;
      dy_q       <= '0;
      height_q   <= '0;
      root_q     <= '0;
      ratio_q    <= '0;
      flag_q     <= 1'b0;
      cnt_q      <= '0;
      sqrt_in_q  <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      tilt_q     <= '0;
      d_gt_h_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            dx_q     <= bus.dx;
            dy_q     <= bus.dy;
            height_q <= bus.height;
          end
        end
        S_SQUARE:     sqrt_in_q <= sum_sq;
        S_SQRT_START: cnt_q <= CNT_LOAD;
        S_SQRT_WAIT: begin
          if (bus.sqrt_ready) root_q    <= bus.sqrt_out;
          else if (tc_hit)    timeout_q <= 1'b1;
          else                cnt_q     <= cnt_q - 1'b1;
        end
        S_ORDER: begin
          dividend_q <= root_gt_h ? height_q : root_q;
          divisor_q  <= root_gt_h ? root_q : height_q;
          flag_q     <= root_gt_h;
          ratio_q    <= (root_q == 12'd0) ? 12'h000 : 12'hFFF;
        end
        S_DIV_START:  cnt_q <= CNT_LOAD;
        S_DIV_WAIT: begin
          if (bus.div_ready) begin
            tilt_q   <= bus.div_quotient;
            d_gt_h_q <= flag_q;
          end else if (tc_hit) begin
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_BYPASS: begin
          tilt_q   <= ratio_q;
          d_gt_h_q <= flag_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.sqrt_in          = sqrt_in_q;
  assign bus.div_dividend     = dividend_q;
  assign bus.div_divisor      = divisor_q;
  assign bus.tilt_ratio       = tilt_q;
  assign bus.d_greater_than_h = d_gt_h_q;
  assign bus.timeout_err      = timeout_q;

endmodule
